serial_subtractor: RTL and testbench

- Bit-serial subtractor; the counterpart of the team's structural 4-bit ripple-carry adder.
- Computes out = a - b - bin with borrow-out, one bit per clock, LSB first, through a single full-subtractor cell.
- Operands are accepted with a valid/ready handshake; the result is held under backpressure.
- Used where a subtract is needed at minimal area and multi-cycle latency is acceptable.

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings
// and the default operand width.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin (in); d, bout (out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb;

    assign axb  = a ^ b;
    assign d    = axb ^ bin;
    // Borrow when b exceeds a, or when they match and a borrow arrives.
    assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: out = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, bin;
// out_valid/out_ready + out, borrow; ovf only when SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q;
    logic               d;
    logic               bout;
    logic               last;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br_q),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = res_q;
    assign borrow    = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && last) begin
            ovf_q <= br_q ^ bout;
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br_q  <= bin;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    // Result fills from the MSB so bit 0 lands last.
                    res_q <= {d, res_q[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    br_q  <= bout;
                    if (last) begin
                        borrow_q <= bout;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=16.
// Build with +define+SERIAL_SUB_OVF_EN to include the ovf checks.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    logic        iv4, ir4, vld4, ordy4, bin4, bo4;
    logic [3:0]  a4, b4, o4;
    logic        iv16, ir16, vld16, ordy16, bin16, bo16;
    logic [15:0] a16, b16, o16;
`ifdef SERIAL_SUB_OVF_EN
    logic        of4, of16;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .bin       (bin4),
        .out_valid (vld4),
        .out_ready (ordy4),
        .out       (o4),
        .borrow    (bo4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (of4)
`endif
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .bin       (bin16),
        .out_valid (vld16),
        .out_ready (ordy16),
        .out       (o16),
        .borrow    (bo16)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (of16)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input int w, input longint a,
                                  input longint b, input int bi,
                                  output longint o, output bit bo,
                                  output bit ov);
        longint m, half, d, sa, sb, sd;
        m    = longint'(1) << w;
        half = m / 2;
        d    = a - b - bi;
        bo   = (d < 0);
        o    = (d + m) % m;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        sd   = sa - sb - bi;
        ov   = (sd < -half) || (sd > half - 1);
    endfunction

    task automatic op(input int w, input logic [15:0] a,
                      input logic [15:0] b, input logic bi,
                      output logic [15:0] o, output logic bo,
                      output logic ovq, output int lat);
        int n = 0;
        while (!(w == 4 ? ir4 : ir16) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) chk("ready_timeout", 64'd0, 64'd1);
        if (w == 4) begin
            iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bin4 = bi;
        end else begin
            iv16 = 1'b1; a16 = a; b16 = b; bin16 = bi;
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        iv16 = 1'b0;
        lat = 0;
        while (!(w == 4 ? vld4 : vld16) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 40) chk("valid_timeout", 64'd0, 64'd1);
        o  = (w == 4) ? {12'b0, o4} : o16;
        bo = (w == 4) ? bo4 : bo16;
        ovq = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovq = (w == 4) ? of4 : of16;
`endif
        if (w == 4) ordy4 = 1'b1; else ordy16 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
        ordy16 = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] out;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t tbl[4];
    vec_t otbl[3];

    initial begin
        logic [15:0] o;
        logic        bo, ovq, bad;
        int          lat, n;
        longint      mo;
        bit          mbo, mov;

        rst = 1'b1;
        iv4 = 0; a4 = 0; b4 = 0; bin4 = 0; ordy4 = 0;
        iv16 = 0; a16 = 0; b16 = 0; bin16 = 0; ordy16 = 0;

        tbl[0] = '{4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0};
        tbl[1] = '{4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0};
        tbl[2] = '{4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[3] = '{4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0};
        otbl[0] = '{4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1};
        otbl[1] = '{4'd7, 4'hF, 1'b0, 4'd8, 1'b1, 1'b1};
        otbl[2] = '{4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(ir4), 64'd1);
        chk("rst_out_valid", 64'(vld4), 64'd0);
        chk("rst_out", 64'(o4), 64'd0);
        chk("rst_borrow", 64'(bo4), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 64'(of4), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            op(4, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].bin, o, bo, ovq, lat);
            chk($sformatf("tbl%0d_out", i), 64'(o), 64'(tbl[i].out));
            chk($sformatf("tbl%0d_borrow", i), 64'(bo), 64'(tbl[i].borrow));
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
        end

        // Backpressure: result held while out_ready=0, new operands ignored.
        iv4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0;
        n = 0;
        while (!vld4 && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_reach_done", 64'(vld4), 64'd1);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out", 64'(o4), 64'd6);
            chk("bp_borrow", 64'(bo4), 64'd0);
            chk("bp_in_ready", 64'(ir4), 64'd0);
            chk("bp_out_valid", 64'(vld4), 64'd1);
        end
        ordy4 = 1'b1;
        @(posedge clk); #1;
        chk("rel_out_valid", 64'(vld4), 64'd0);
        chk("rel_in_ready", 64'(ir4), 64'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        chk("rel_accepted", 64'(ir4), 64'd0);
        n = 0;
        while (!vld4 && n < 40) begin @(posedge clk); #1; n++; end
        chk("rel_out", 64'(o4), 64'hF);
        chk("rel_borrow", 64'(bo4), 64'd0);
        @(posedge clk); #1;
        ordy4 = 1'b0;

        // Reset during the second BUSY cycle discards the operation.
        iv4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(ir4), 64'd1);
        chk("mid_rst_out_valid", 64'(vld4), 64'd0);
        chk("mid_rst_out", 64'(o4), 64'd0);
        chk("mid_rst_borrow", 64'(bo4), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("mid_rst_ovf", 64'(of4), 64'd0);
`endif
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (vld4) bad = 1'b1;
        end
        chk("mid_rst_no_valid", 64'(bad), 64'd0);
        op(4, 16'd7, 16'd2, 1'b0, o, bo, ovq, lat);
        chk("after_rst_out", 64'(o), 64'd5);
        chk("after_rst_borrow", 64'(bo), 64'd0);

`ifdef SERIAL_SUB_OVF_EN
        for (int i = 0; i < 3; i++) begin
            op(4, 16'(otbl[i].a), 16'(otbl[i].b), otbl[i].bin, o, bo, ovq, lat);
            chk($sformatf("ovf%0d_out", i), 64'(o), 64'(otbl[i].out));
            chk($sformatf("ovf%0d_borrow", i), 64'(bo), 64'(otbl[i].borrow));
            chk($sformatf("ovf%0d_ovf", i), 64'(ovq), 64'(otbl[i].ovf));
        end
`endif

        // Exhaustive sweep at WIDTH=4.
        for (int v = 0; v < 512; v++) begin
            logic [3:0] ea, eb;
            logic       ebi;
            ea  = v[3:0];
            eb  = v[7:4];
            ebi = v[8];
            model(4, longint'(ea), longint'(eb), int'(ebi), mo, mbo, mov);
            op(4, 16'(ea), 16'(eb), ebi, o, bo, ovq, lat);
            chk($sformatf("sw4 %0d-%0d-%0d out", ea, eb, ebi), 64'(o), 64'(mo));
            chk($sformatf("sw4 %0d-%0d-%0d borrow", ea, eb, ebi),
                64'(bo), 64'(mbo));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("sw4 %0d-%0d-%0d ovf", ea, eb, ebi),
                64'(ovq), 64'(mov));
`endif
        end

        // Random vectors at WIDTH=16.
        for (int v = 0; v < 1000; v++) begin
            logic [15:0] ra, rb;
            logic        rbi;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            model(16, longint'(ra), longint'(rb), int'(rbi), mo, mbo, mov);
            op(16, ra, rb, rbi, o, bo, ovq, lat);
            chk($sformatf("r16 %0h-%0h-%0d out", ra, rb, rbi), 64'(o), 64'(mo));
            chk($sformatf("r16 %0h-%0h-%0d borrow", ra, rb, rbi),
                64'(bo), 64'(mbo));
            if (v < 10) chk("r16_latency", 64'(lat), 64'd16);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("r16 %0h-%0h-%0d ovf", ra, rb, rbi),
                64'(ovq), 64'(mov));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
